// File: rtl/shreg_pkg.sv
// rtl/shreg_pkg.sv - shared encodings and state type for the shift-register sequencer
package shreg_pkg;

    // Register S-pin encodings (74HC194 mode select)
    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_SR   = 2'b01;
    localparam logic [1:0] S_SL   = 2'b10;
    localparam logic [1:0] S_LOAD = 2'b11;

    // Sequencer operating modes
    localparam logic [1:0] MODE_ROR = 2'b00;
    localparam logic [1:0] MODE_ROL = 2'b01;
    localparam logic [1:0] MODE_SRF = 2'b10;
    localparam logic [1:0] MODE_SLF = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_SHIFT,
        ST_DONE
    } state_e;

    // Left-going modes (ROL, SLF) have bit 0 set; all others shift right.
    function automatic logic [1:0] shift_sel(input logic [1:0] mode);
        return mode[0] ? S_SL : S_SR;
    endfunction

endpackage

// File: rtl/shreg_seq_ctrl_ivl_timer.sv
// rtl/shreg_seq_ctrl_ivl_timer.sv - loadable down-counter timing the idle interval
//
// Ports:
//   clk        rising-edge clock
//   MR         asynchronous active-low reset
//   load_i     load load_val_i into the counter
//   load_val_i value loaded (remaining cycles minus one)
//   dec_i      decrement while non-zero
//   expired_o  counter has reached zero
module ivl_timer #(
    parameter int IVL_W = 8
) (
    input  logic             clk,
    input  logic             MR,
    input  logic             load_i,
    input  logic [IVL_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expired_o
);

    logic [IVL_W-1:0] cnt_q;
    logic [IVL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - IVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge MR) begin
        if (!MR) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/shreg_seq_ctrl.sv
// rtl/shreg_seq_ctrl.sv - load/step sequencer driving a 4-bit universal shift register
//
// Ports:
//   clk, MR            clock and asynchronous active-low reset (shared with register MR)
//   start, abort       command strobe (IDLE only) and cancel
//   mode, pattern,     command fields latched on an accepted start
//   steps, interval,
//   fill
//   Q_fb               register outputs Q[0:3] for rotate feedback
//   S, D, Dsr, Dsl     register control, parallel data and serial inputs
//   busy, done         activity flag and one-cycle completion pulse
//   step_cnt           shift steps completed in the current operation
module shreg_seq_ctrl
    import shreg_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int IVL_W = 8
) (
    input  logic             clk,
    input  logic             MR,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [3:0]       pattern,
    input  logic [CNT_W-1:0] steps,
    input  logic [IVL_W-1:0] interval,
    input  logic             fill,
    input  logic [3:0]       Q_fb,
    output logic [1:0]       S,
    output logic [3:0]       D,
    output logic             Dsr,
    output logic             Dsl,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] step_cnt
);

    state_e           state_q, state_d;
    logic [1:0]       mode_q;
    logic [3:0]       pat_q;
    logic [CNT_W-1:0] steps_q;
    logic [IVL_W-1:0] ivl_q;
    logic             fill_q;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

    logic             accept;
    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_expired;
    logic             last_step;

    assign accept    = (state_q == ST_IDLE) && start;
    assign last_step = ((step_cnt_q + CNT_W'(1)) == steps_q);

    // The timer is loaded with I-1 on entry to WAIT so that WAIT lasts I cycles.
    ivl_timer #(
        .IVL_W (IVL_W)
    ) u_ivl_timer (
        .clk        (clk),
        .MR         (MR),
        .load_i     (tmr_load),
        .load_val_i (ivl_q - IVL_W'(1)),
        .dec_i      (tmr_dec),
        .expired_o  (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // start beats a simultaneous abort here
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (steps_q == '0) begin
                    state_d = ST_DONE;
                end else if (ivl_q != '0) begin
                    state_d  = ST_WAIT;
                    tmr_load = 1'b1;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_expired) begin
                    state_d = ST_SHIFT;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (last_step) begin
                    state_d = ST_DONE;
                end else if (ivl_q != '0) begin
                    state_d  = ST_WAIT;
                    tmr_load = 1'b1;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The register shifts on every SHIFT closing edge, even an aborted one,
    // so the count tracks what physically happened to Q.
    always_comb begin
        step_cnt_d = step_cnt_q;
        if (accept) begin
            step_cnt_d = '0;
        end else if (state_q == ST_SHIFT) begin
            step_cnt_d = step_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge MR) begin
        if (!MR) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_ROR;
            pat_q      <= '0;
            steps_q    <= '0;
            ivl_q      <= '0;
            fill_q     <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            if (accept) begin
                mode_q  <= mode;
                pat_q   <= pattern;
                steps_q <= steps;
                ivl_q   <= interval;
                fill_q  <= fill;
            end
        end
    end

    // Register controls come from registered state only.
    always_comb begin
        S = S_HOLD;
        D = '0;
        unique case (state_q)
            ST_LOAD: begin
                S = S_LOAD;
                D = pat_q;
            end
            ST_SHIFT: begin
                S = shift_sel(mode_q);
            end
            default: begin
                S = S_HOLD;
            end
        endcase
    end

    assign Dsr      = (mode_q == MODE_ROR) ? Q_fb[3] : fill_q;
    assign Dsl      = (mode_q == MODE_ROL) ? Q_fb[0] : fill_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign step_cnt = step_cnt_q;

endmodule
